// File: rtl/miner_pkg.sv
// Shared definitions for the miner control path: the controller state
// encoding observed by the shift timer.
package miner_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    IDLE      = 3'b000,
    LOAD_MID  = 3'b001,
    LOAD_REM  = 3'b010,
    HASH_RUN  = 3'b011,
    HASH_WAIT = 3'b100,
    NEXT      = 3'b101,
    FOUND     = 3'b110,
    EXHAUSTED = 3'b111
  } ctrl_state_t;

endpackage

// File: rtl/hash_watchdog.sv
// Cycle counter that flags a hash core that never answers. Counts while
// enabled, clears on request; TIMEOUT of 0 disables the expired flag.
module hash_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry fires during the cycle whose increment would reach TIMEOUT, so
  // the owner leaves its wait state exactly TIMEOUT cycles after entry.
  assign expired = (TIMEOUT != 0) && en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mining_sequencer.sv
// Job sequencer: walks header loading, then hashes each nonce of the
// configured range until a hit, exhaustion, timeout or abort.
module mining_sequencer #(
  parameter int          NONCE_W      = 32,
  parameter int unsigned HASH_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic               midstate_shifts_done,
  input  logic               remaining_shifts_done,
  input  logic               hash_done,
  input  logic               hash_lt_target,
  output logic [2:0]         controller_state,
  output logic               hash_start,
  output logic [NONCE_W-1:0] nonce,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err,
  output logic               busy
);

  import miner_pkg::*;

  ctrl_state_t        state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] last_q, last_d;
  logic               found_q, found_d;
  logic               exhausted_q, exhausted_d;
  logic               timeout_q, timeout_d;
  logic               wd_expired;

  // Counter is held clear outside HASH_WAIT, so every entry starts at zero.
  hash_watchdog #(
    .TIMEOUT (HASH_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (state_q != HASH_WAIT),
    .en      (state_q == HASH_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    last_d      = last_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    timeout_d   = timeout_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, FOUND, EXHAUSTED: begin
          if (job_start) begin
            state_d     = LOAD_MID;
            nonce_d     = nonce_first;
            last_d      = nonce_last;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
          end
        end
        LOAD_MID:  if (midstate_shifts_done) state_d = LOAD_REM;
        LOAD_REM:  if (remaining_shifts_done) state_d = HASH_RUN;
        HASH_RUN:  state_d = HASH_WAIT;
        HASH_WAIT: begin
          if (hash_done) begin
            if (hash_lt_target) begin
              state_d = FOUND;
              found_d = 1'b1;
            end else begin
              state_d = NEXT;
            end
          end else if (wd_expired) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
        NEXT: begin
          // Inclusive bound; the increment wraps naturally for reversed ranges.
          if (nonce_q == last_q) begin
            state_d     = EXHAUSTED;
            exhausted_d = 1'b1;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = HASH_RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      nonce_q     <= '0;
      last_q      <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      last_q      <= last_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      timeout_q   <= timeout_d;
    end
  end

  assign controller_state = state_q;
  assign hash_start       = (state_q == HASH_RUN);
  assign nonce            = nonce_q;
  assign found            = found_q;
  assign exhausted        = exhausted_q;
  assign timeout_err      = timeout_q;
  assign busy             = !((state_q == IDLE) || (state_q == FOUND) ||
                              (state_q == EXHAUSTED));

endmodule

// File: tb/tb_mining_sequencer.sv
// Directed bench for mining_sequencer: table of whole jobs plus hand-written
// reset, timeout and abort/priority sequences.
module tb_mining_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        job_start;
  logic        abort;
  logic [31:0] nonce_first;
  logic [31:0] nonce_last;
  logic        midstate_shifts_done;
  logic        remaining_shifts_done;
  logic        hash_done;
  logic        hash_lt_target;
  logic [2:0]  controller_state;
  logic        hash_start;
  logic [31:0] nonce;
  logic        found;
  logic        exhausted;
  logic        timeout_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int nh;
  logic [31:0] tested_q[$];

  mining_sequencer #(
    .NONCE_W      (32),
    .HASH_TIMEOUT (15)
  ) dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .job_start             (job_start),
    .abort                 (abort),
    .nonce_first           (nonce_first),
    .nonce_last            (nonce_last),
    .midstate_shifts_done  (midstate_shifts_done),
    .remaining_shifts_done (remaining_shifts_done),
    .hash_done             (hash_done),
    .hash_lt_target        (hash_lt_target),
    .controller_state      (controller_state),
    .hash_start            (hash_start),
    .nonce                 (nonce),
    .found                 (found),
    .exhausted             (exhausted),
    .timeout_err           (timeout_err),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] first;
    logic [31:0] last;
    logic        hit_en;
    logic [31:0] hit;
    logic [2:0]  exp_state;
    logic [31:0] exp_nonce;
    logic        exp_found;
    logic        exp_exh;
    int          exp_hashes;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a job and plays timer and hash core until the sequencer settles,
  // or until HASH_WAIT is reached when stop_wait is set.
  task automatic run_job(input logic [31:0] first, input logic [31:0] last,
                         input logic hit_en, input logic [31:0] hit,
                         input bit stop_wait);
    int  midc, remc, waitc;
    bit  done;
    midc = 0; remc = 0; waitc = 0; done = 0; nh = 0;
    tested_q.delete();
    nonce_first = first;
    nonce_last  = last;
    job_start   = 1'b1;
    tick();
    job_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      midstate_shifts_done  = 1'b0;
      remaining_shifts_done = 1'b0;
      hash_done             = 1'b0;
      hash_lt_target        = 1'b0;
      if (hash_start) begin
        nh++;
        tested_q.push_back(nonce);
      end
      case (controller_state)
        3'd1: begin midc++; if (midc == 8) midstate_shifts_done = 1'b1; end
        3'd2: begin remc++; if (remc == 16) remaining_shifts_done = 1'b1; end
        3'd3: waitc = 0;
        3'd4: begin
          if (stop_wait) done = 1;
          else begin
            waitc++;
            if (waitc == 3) begin
              hash_done      = 1'b1;
              hash_lt_target = hit_en && (nonce == hit);
            end
          end
        end
        3'd5: ;
        default: done = 1;
      endcase
      if (!done) tick();
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL job_budget: state %0h never settled", controller_state);
    end
  endtask

  initial begin
    n_rst = 1'b0; job_start = 1'b0; abort = 1'b0;
    nonce_first = '0; nonce_last = '0;
    midstate_shifts_done = 1'b0; remaining_shifts_done = 1'b0;
    hash_done = 1'b0; hash_lt_target = 1'b0;

    vecs[0] = '{32'd5, 32'd7, 1'b1, 32'd7, 3'b110, 32'd7, 1'b1, 1'b0, 3};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 3'b111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1};
    vecs[2] = '{32'hFFFF_FFFE, 32'd1, 1'b0, 32'd0, 3'b111, 32'd1, 1'b0, 1'b1, 4};
    vecs[3] = '{32'd10, 32'd12, 1'b1, 32'd10, 3'b110, 32'd10, 1'b1, 1'b0, 1};
    vecs[4] = '{32'd0, 32'd0, 1'b1, 32'd0, 3'b110, 32'd0, 1'b1, 1'b0, 1};

    @(negedge clk);
    tick();
    chk("rst_state", {29'd0, controller_state}, 32'd0);
    chk("rst_nonce", nonce, 32'd0);
    chk("rst_flags", {28'd0, found, exhausted, timeout_err, hash_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    n_rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].first, vecs[v].last, vecs[v].hit_en, vecs[v].hit, 1'b0);
      chk($sformatf("v%0d_state", v), {29'd0, controller_state}, {29'd0, vecs[v].exp_state});
      chk($sformatf("v%0d_nonce", v), nonce, vecs[v].exp_nonce);
      chk($sformatf("v%0d_found", v), {31'd0, found}, {31'd0, vecs[v].exp_found});
      chk($sformatf("v%0d_exh", v), {31'd0, exhausted}, {31'd0, vecs[v].exp_exh});
      chk($sformatf("v%0d_tmo", v), {31'd0, timeout_err}, 32'd0);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_hashes", v), nh, vecs[v].exp_hashes);
      for (int k = 0; k < tested_q.size(); k++)
        chk($sformatf("v%0d_seq%0d", v, k), tested_q[k], vecs[v].first + k);
    end

    // Abort wins over job_start in LOAD_REM; job_start in FOUND clears found.
    nonce_first = 32'd20; nonce_last = 32'd30;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    chk("fnd_restart_state", {29'd0, controller_state}, 32'd1);
    chk("fnd_restart_found", {31'd0, found}, 32'd0);
    chk("fnd_restart_nonce", nonce, 32'd20);
    for (int i = 0; i < 40 && controller_state != 3'd2; i++) begin
      midstate_shifts_done = (controller_state == 3'd1);
      tick();
    end
    midstate_shifts_done = 1'b0;
    chk("abort_in_rem", {29'd0, controller_state}, 32'd2);
    abort = 1'b1; job_start = 1'b1; hash_done = 1'b1;
    tick();
    abort = 1'b0; job_start = 1'b0; hash_done = 1'b0;
    chk("abort_state", {29'd0, controller_state}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of HASH_WAIT.
    run_job(32'd3, 32'd9, 1'b0, 32'd0, 1'b1);
    chk("pre_rst_wait", {29'd0, controller_state}, 32'd4);
    n_rst = 1'b0;
    tick();
    chk("midrst_state", {29'd0, controller_state}, 32'd0);
    chk("midrst_nonce", nonce, 32'd0);
    chk("midrst_flags", {28'd0, found, exhausted, timeout_err, hash_start}, 32'd0);
    tick();
    n_rst = 1'b1;

    // Silent hash core: timeout exactly 15 cycles after entering HASH_WAIT.
    run_job(32'd100, 32'd200, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_still_wait", {29'd0, controller_state}, 32'd4);
    chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("tmo_state", {29'd0, controller_state}, 32'd0);
    chk("tmo_flag", {31'd0, timeout_err}, 32'd1);
    chk("tmo_nonce_held", nonce, 32'd100);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("rst_clears_tmo", {31'd0, timeout_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
